// File: rtl/master_port_pkg.sv
// Shared types and sizing helpers for the serial bus master port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package master_port_pkg;

    // Transaction phases of the master port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam int DEF_N   = 8;
    localparam int DEF_ADN = 12;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first shift register: parallel load, serial out from the MSB, serial in at the LSB.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none; shifts only when shift_i is high, load wins over shift.
module serial_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] par_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] par_o,
    output logic         ser_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Next value: load a new word, or move everything one place toward the MSB.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = par_i;
        end else if (shift_i) begin
            sr_d = W'({sr_q, ser_i});
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_o = sr_q;
    assign ser_o = sr_q[W-1];

endmodule

// File: rtl/master_port.sv
// Converts a parallel read/write request into a serial slave transaction and collects read data.
// Latency: write completes ADN+2 cycles after acceptance; read completes N+1 cycles after slave header.
// Backpressure: req_ready only in IDLE with slv_ready_i high; optional read timeout via MASTER_PORT_TIMEOUT_EN.
module master_port
    import master_port_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int ADN     = DEF_ADN,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_wr,
    input  logic [ADN-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           resp_valid,
    output logic [N-1:0]   resp_rdata,
    output logic           resp_err,
    output logic           slv_valid_o,
    output logic           slv_wren_o,
    output logic           slv_addr_o,
    output logic           slv_data_o,
    input  logic           slv_ready_i,
    input  logic           slv_valid_i,
    input  logic           slv_data_i
);

    localparam int CW = cnt_width(ADN);

    // Configuration sanity: write data is aligned to the tail of the address burst.
    if (ADN < N || TIMEOUT < 1) begin : g_bad_cfg
        $error("master_port: need ADN >= N and TIMEOUT >= 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [N-1:0]  rdata_q, rdata_d;

    logic          accept;
    logic          addr_shift;
    logic          data_shift;
    logic          rd_shift;
    logic          data_win;
    logic          addr_ser;
    logic          data_ser;
    logic [N-1:0]  rd_par;

    logic [ADN-1:0] addr_par_unused;
    logic [N-1:0]   data_par_unused;
    logic           rd_ser_unused;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT);
    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
`endif

    // Reset gates ready so every output reads 0 while rstn is low.
    assign req_ready = rstn && (state_q == IDLE) && slv_ready_i;
    assign accept    = req_valid && req_ready;
    // Write data rides on the last N address beats.
    assign data_win  = (cnt_q >= CW'(ADN - N));

    serial_shift_reg #(.W(ADN)) u_addr_sr (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (accept),
        .par_i   (req_addr),
        .shift_i (addr_shift),
        .ser_i   (1'b0),
        .par_o   (addr_par_unused),
        .ser_o   (addr_ser)
    );

    serial_shift_reg #(.W(N)) u_wdata_sr (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (accept),
        .par_i   (req_wdata),
        .shift_i (data_shift),
        .ser_i   (1'b0),
        .par_o   (data_par_unused),
        .ser_o   (data_ser)
    );

    serial_shift_reg #(.W(N)) u_rdata_sr (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (accept),
        .par_i   ({N{1'b0}}),
        .shift_i (rd_shift),
        .ser_i   (slv_data_i),
        .par_o   (rd_par),
        .ser_o   (rd_ser_unused)
    );

    // Next-state, beat counting and shift enables for each transaction phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        rd_shift   = 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
        wait_d     = wait_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HDR;
                    wr_d    = req_wr;
                    cnt_d   = '0;
                end
            end
            HDR: begin
                state_d = ADDR;
                cnt_d   = '0;
            end
            ADDR: begin
                addr_shift = 1'b1;
                data_shift = wr_q && data_win;
                if (cnt_q == CW'(ADN - 1)) begin
                    state_d = wr_q ? RESP : RWAIT;
                    cnt_d   = '0;
`ifdef MASTER_PORT_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RWAIT: begin
                // First valid cycle from the slave is its header; drop it.
                if (slv_valid_i) begin
                    state_d = RDATA;
                    cnt_d   = '0;
                end
`ifdef MASTER_PORT_TIMEOUT_EN
                else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
`endif
            end
            RDATA: begin
                if (slv_valid_i) begin
                    rd_shift = 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = RESP;
                        cnt_d   = '0;
                        rdata_d = N'({rd_par, slv_data_i});
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef MASTER_PORT_TIMEOUT_EN
                else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
`ifdef MASTER_PORT_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Phase, beat counter, direction and completed read word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MASTER_PORT_TIMEOUT_EN
    // Read-wait counter and sticky timeout flag for the current transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign resp_err = (state_q == RESP) && err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign slv_valid_o = (state_q == HDR) || (state_q == ADDR);
    assign slv_wren_o  = slv_valid_o && wr_q;
    assign slv_addr_o  = (state_q == ADDR) && addr_ser;
    assign slv_data_o  = (state_q == ADDR) && wr_q && data_win && data_ser;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: writes, reads, ready stall, mid-burst reset, read timeout.
// Latency: checks cycle-exact completion timing against hand-computed values.
// Backpressure: exercises slv_ready_i low with a pending request.
module tb_master_port;

    localparam int N       = 8;
    localparam int ADN     = 12;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_wr = 1'b0;
    logic [ADN-1:0] req_addr = '0;
    logic [N-1:0]   req_wdata = '0;
    logic           resp_valid;
    logic [N-1:0]   resp_rdata;
    logic           resp_err;
    logic           slv_valid_o;
    logic           slv_wren_o;
    logic           slv_addr_o;
    logic           slv_data_o;
    logic           slv_ready_i = 1'b0;
    logic           slv_valid_i = 1'b0;
    logic           slv_data_i = 1'b0;

    always #5 clk = ~clk;

    master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .slv_valid_o (slv_valid_o),
        .slv_wren_o  (slv_wren_o),
        .slv_addr_o  (slv_addr_o),
        .slv_data_o  (slv_data_o),
        .slv_ready_i (slv_ready_i),
        .slv_valid_i (slv_valid_i),
        .slv_data_i  (slv_data_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last run_txn call.
    int         r_beats, r_resp_cyc, r_nresp;
    logic [11:0] r_addr;
    logic [7:0]  r_data, r_rdata;
    logic        r_err, r_hdr_ok, r_sig_ok, r_rdy_resp, r_rdy_after;

    // Issue one request and watch maxc cycles. Slave header at cycle hdr (<0: none),
    // then rd MSB first; gap>=0 inserts one idle cycle after that many data bits.
    task automatic run_txn(input logic wr, input logic [11:0] a, input logic [7:0] wd,
                           input int hdr, input logic [7:0] rd, input int gap, input int maxc);
        int t, j, b;
        r_beats = 0; r_resp_cyc = -1; r_nresp = 0;
        r_addr = '0; r_data = '0; r_rdata = '0; r_err = 1'b0;
        r_hdr_ok = 1'b1; r_sig_ok = 1'b1; r_rdy_resp = 1'b1; r_rdy_after = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; slv_ready_i = 1'b1;
        #1;
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            slv_valid_i = 1'b0; slv_data_i = 1'b0;
            if (hdr >= 0) begin
                t = c - hdr - 1;
                if (c == hdr) slv_valid_i = 1'b1;
                else if (t >= 0) begin
                    if (gap >= 0 && t == gap) j = -1;
                    else if (gap >= 0 && t > gap) j = t - 1;
                    else j = t;
                    if (j >= 0 && j < 8) begin
                        slv_valid_i = 1'b1;
                        slv_data_i  = rd[7-j];
                    end
                end
            end
            #1;
            if (slv_valid_o) begin
                b = r_beats;
                r_beats++;
                if (slv_wren_o !== wr) r_sig_ok = 1'b0;
                if (b == 0) begin
                    if (slv_addr_o !== 1'b0 || slv_data_o !== 1'b0) r_hdr_ok = 1'b0;
                end else begin
                    r_addr = {r_addr[10:0], slv_addr_o};
                    if (b >= 5) r_data = {r_data[6:0], slv_data_o};
                    else if (slv_data_o !== 1'b0) r_sig_ok = 1'b0;
                end
            end else if (slv_wren_o !== 1'b0 || slv_addr_o !== 1'b0 || slv_data_o !== 1'b0) begin
                r_sig_ok = 1'b0;
            end
            if (r_resp_cyc >= 0 && c == r_resp_cyc + 1) r_rdy_after = req_ready;
            if (resp_valid) begin
                r_nresp++;
                if (r_resp_cyc < 0) begin
                    r_resp_cyc = c; r_rdata = resp_rdata; r_err = resp_err; r_rdy_resp = req_ready;
                end
            end
        end
        slv_valid_i = 1'b0; slv_data_i = 1'b0;
    endtask

    function automatic logic [14:0] outs();
        return {req_ready, resp_valid, resp_rdata, resp_err,
                slv_valid_o, slv_wren_o, slv_addr_o, slv_data_o};
    endfunction

    initial begin
        int nresp;

        // Reset: ready must stay low even with the slave ready and a request waiting.
        slv_ready_i = 1'b1; req_valid = 1'b1;
        @(negedge clk); #1;
        check("reset_outputs", {17'd0, outs()}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        check("idle_outputs", {17'd0, outs()}, {17'd0, 15'h4000});

        // Write 0xA5C <- 0x3B.
        run_txn(1'b1, 12'hA5C, 8'h3B, -1, 8'h00, -1, 20);
        check("wr_beats",      r_beats, 13);
        check("wr_hdr_zero",   {31'd0, r_hdr_ok}, 32'd1);
        check("wr_addr_bits",  {20'd0, r_addr}, 32'hA5C);
        check("wr_data_bits",  {24'd0, r_data}, 32'h3B);
        check("wr_wren_lines", {31'd0, r_sig_ok}, 32'd1);
        check("wr_resp_cycle", r_resp_cyc, 14);
        check("wr_resp_err",   {31'd0, r_err}, 32'd0);
        check("wr_resp_count", r_nresp, 1);
        check("wr_ready_resp", {31'd0, r_rdy_resp}, 32'd0);
        check("wr_ready_after",{31'd0, r_rdy_after}, 32'd1);

        // Slave valid while idle is ignored.
        @(negedge clk); slv_valid_i = 1'b1; slv_data_i = 1'b1;
        @(negedge clk); slv_valid_i = 1'b0; slv_data_i = 1'b0; #1;
        check("idle_ignore", {29'd0, req_ready, resp_valid, slv_valid_o}, 32'd4);

        // Reset during ADDR beat 4 (cycle 6) aborts without a response.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'hFFF; req_wdata = 8'hFF;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        #1;
        check("abort_in_addr", {31'd0, slv_valid_o}, 32'd1);
        rstn = 1'b0; #1;
        check("abort_outputs", {17'd0, outs()}, 32'd0);
        nresp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (resp_valid) nresp++;
        end
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (resp_valid || slv_valid_o) nresp++;
        end
        check("abort_no_resp", nresp, 0);
        run_txn(1'b1, 12'h3C5, 8'hE1, -1, 8'h00, -1, 20);
        check("recov_addr", {20'd0, r_addr}, 32'h3C5);
        check("recov_data", {24'd0, r_data}, 32'hE1);
        check("recov_resp_cycle", r_resp_cyc, 14);

        // Pending request while the slave is busy.
        @(negedge clk);
        slv_ready_i = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'h7E1; req_wdata = 8'h96;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("busy_no_accept", {30'd0, req_ready, slv_valid_o}, 32'd0);
        end
        run_txn(1'b1, 12'h7E1, 8'h96, -1, 8'h00, -1, 20);
        check("stall_resp_cycle", r_resp_cyc, 14);
        check("stall_addr", {20'd0, r_addr}, 32'h7E1);
        check("stall_data", {24'd0, r_data}, 32'h96);

        // Read 0x123, slave header at cycle 34, returns 0xC6.
        run_txn(1'b0, 12'h123, 8'hFF, 34, 8'hC6, -1, 50);
        check("rd_beats",      r_beats, 13);
        check("rd_addr_bits",  {20'd0, r_addr}, 32'h123);
        check("rd_lines",      {31'd0, r_sig_ok}, 32'd1);
        check("rd_resp_cycle", r_resp_cyc, 43);
        check("rd_rdata",      {24'd0, r_rdata}, 32'hC6);
        check("rd_resp_err",   {31'd0, r_err}, 32'd0);
        check("rd_hold",       {24'd0, resp_rdata}, 32'hC6);

        // Read with slv_valid_i dropping for one cycle after three data bits.
        run_txn(1'b0, 12'h0F0, 8'h00, 34, 8'h5A, 3, 50);
        check("rd_gap_resp_cycle", r_resp_cyc, 44);
        check("rd_gap_rdata", {24'd0, r_rdata}, 32'h5A);
        check("rd_gap_count", r_nresp, 1);

        // Read with no slave answer.
        run_txn(1'b0, 12'h456, 8'h00, -1, 8'h00, -1, 90);
`ifdef MASTER_PORT_TIMEOUT_EN
        check("to_resp_cycle", r_resp_cyc, 78);
        check("to_resp_err",   {31'd0, r_err}, 32'd1);
        check("to_rdata_kept", {24'd0, r_rdata}, 32'h5A);
`else
        check("to_no_resp",    r_nresp, 0);
        #1;
        check("to_ready_low",  {31'd0, req_ready}, 32'd0);
        check("to_rdata_kept", {24'd0, resp_rdata}, 32'h5A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_port.md
# master_port

Bus-side master interface that converts one parallel read/write request from a master core into the serial bit-level transaction consumed by a memory slave. It drives valid, write-enable, serial address and serial write data, then deserialises returned read data into a parallel response. It sits directly upstream of the slave on the same single-clock serial bus.

## Interface
- Parameters:
- `N`, 8, data word width in bits.
- `ADN`, 12, address width in bits; must satisfy ADN ≥ N.
- `TIMEOUT`, 64, read-wait cycle limit; used only when the timeout feature is compiled in.
- Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  bus clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  port idle and slave ready; request accepted when valid&&ready.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADN  target address.
- `req_wdata`  in  N  write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  N  read data; holds its value until the next read completes.
- `resp_err`  out  1  read timed out; valid together with resp_valid.
- `slv_valid_o`  out  1  serial beat valid, to slave.
- `slv_wren_o`  out  1  write enable, to slave.
- `slv_addr_o`  out  1  serial address bit, MSB first.
- `slv_data_o`  out  1  serial write-data bit, MSB first.
- `slv_ready_i`  in  1  slave idle/ready.
- `slv_valid_i`  in  1  slave read-data valid.
- `slv_data_i`  in  1  slave serial read data.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- States:
  - IDLE → HDR on acceptance; req_ready = (state==IDLE) && slv_ready_i. The request is latched into internal address and data shift registers.
  - HDR: one beat with slv_valid_o=1, slv_wren_o=req_wr, addr/data bits 0. The slave uses this beat to leave its idle state. Always goes to ADDR.
  - ADDR: ADN beats with slv_valid_o=1. Beat k (0..ADN-1) carries addr[ADN-1-k]. For writes, beat k ≥ ADN-N also carries wdata[N-1-(k-(ADN-N))] on slv_data_o; otherwise slv_data_o=0. After the last beat: writes go to RESP, reads go to RWAIT.
  - RWAIT: slv_valid_o=0, slv_wren_o=0. Waits for slv_valid_i. The first slv_valid_i-high cycle is a header beat and is discarded; then → RDATA.
  - RDATA: N beats; each beat shifts slv_data_i into the LSB of the read register (MSB arrives first). After N beats → RESP.
  - RESP: resp_valid=1 for one cycle. resp_rdata is updated on reads only. → IDLE.
- slv_wren_o is held stable through HDR and ADDR, and is 0 in all other states.
- slv_valid_i outside RWAIT/RDATA is ignored. If slv_valid_i drops during RDATA, the bit is not shifted, and the beat count waits for it to return.
- A req_valid arriving while busy is not accepted. A request raised in IDLE while slv_ready_i=0 stays pending.
- Reset asserted mid-transaction aborts immediately: all outputs return to 0, no resp_valid is issued, and the slave recovers from its own timeout/idle behaviour.
- Counters: beat counter width $clog2(ADN+1). Wrap-around is never used; counters clear on entry to each state.

## Timing
- Acceptance edge = cycle 0. HDR is driven in cycle 1, address beats in cycles 2..ADN+1.
- Write: resp_valid in cycle ADN+2, giving a total write latency of ADN+2 cycles. req_ready returns in cycle ADN+3 if slv_ready_i=1.
- Read: if the slave's header beat arrives in cycle H, data bits are sampled in H+1..H+N, and resp_valid is asserted in H+N+1.
- Back-to-back requests: no request is accepted in the resp_valid cycle.

## Configuration
- `MASTER_PORT_TIMEOUT_EN` defined: a read-wait counter runs in RWAIT (and RDATA while slv_valid_i=0). When it reaches TIMEOUT the port goes to RESP with resp_err=1 and resp_rdata unchanged. The counter clears on entry to RWAIT.
- Not defined: RWAIT waits indefinitely, resp_err is tied to 0, and the counter logic is absent.

## Structure
- `master_port_pkg`: the state enum (IDLE, HDR, ADDR, RWAIT, RDATA, RESP), default N/ADN constants, and the counter-width function.
- One natural sub-module, `serial_shift_reg`: a parameterised PISO/SIPO shift register with load, shift-enable, MSB-first output and LSB serial input. It is instantiated for the address, write-data and read-data registers.

## Test plan
- Write addr=0xA5C, wdata=0x3B: exactly ADN+1 slv_valid_o beats; address bits 1010_0101_1100 in beats 1..12; data 0011_1011 on beats 5..12; resp_valid at cycle 14, resp_err=0.
- Read addr=0x123 against a slave model with 20-cycle delay returning header+0xC6: resp_rdata=0xC6, resp_valid one cycle after the last data bit.
- req_valid with slv_ready_i=0 for 5 cycles, then 1: no acceptance until slv_ready_i=1; cycle 0 is counted from that edge.
- rstn pulsed low during ADDR beat 4: all outputs 0 asynchronously, no resp_valid; the next request completes correctly.
- With MASTER_PORT_TIMEOUT_EN and TIMEOUT=64, a read with no slave response: resp_valid and resp_err=1 after 64 RWAIT cycles, resp_rdata keeps its prior value. Without the macro: no response, and req_ready stays 0.
